// File: rtl/misc_v_pkg.sv
// Shared widths, dump FSM state names and the bypassed-read helper for the MISC-V register file.
// Pure declarations: no clocked logic and no handshakes live here.
package misc_v_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 2 ** ADDR_W;

  // Highest index held as an ADDR_W-wide constant so the terminal compare cannot wrap.
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } dump_state_t;

  // Same-cycle read: register 0 may be hard-wired to zero, and an accepted write wins over storage.
  function automatic logic [DATA_W-1:0] read_mux(
    input logic              zero_reg,
    input logic [ADDR_W-1:0] addr,
    input logic              wr_hit,
    input logic [ADDR_W-1:0] wr_addr,
    input logic [DATA_W-1:0] wr_data,
    input logic [DATA_W-1:0] stored
  );
    if (zero_reg && (addr == '0)) begin
      return '0;
    end
    if (wr_hit && (wr_addr == addr)) begin
      return wr_data;
    end
    return stored;
  endfunction

endpackage

// File: rtl/register_file_if.sv
// Write port, two read ports and the valid/ready dump stream of the register file.
// master = decode/write-back/debug side, slave = register file.
interface register_file_if;
  import misc_v_pkg::*;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic [ADDR_W-1:0] rd_addr_a;
  logic [DATA_W-1:0] rd_data_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_b;

  logic              dump_start;
  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;
  logic              dump_busy;
  logic              dump_done;

  modport master (
    output wr_en, wr_addr, wr_data,
    output rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b,
    output dump_start, dump_ready,
    input  dump_valid, dump_addr, dump_data, dump_busy, dump_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b,
    input  dump_start, dump_ready,
    output dump_valid, dump_addr, dump_data, dump_busy, dump_done
  );

endinterface

// File: rtl/reg_dump_fsm.sv
// Streams every register out in index order; first beat valid one cycle after dump_start.
// Beat held stable while dump_ready=0; one beat per cycle when ready stays high.
module reg_dump_fsm
  import misc_v_pkg::*;
(
  input  logic              CLK,
  input  logic              reset,
  input  logic              dump_start,
  input  logic              dump_ready,
  input  logic [DATA_W-1:0] peek_data,
  output logic [ADDR_W-1:0] peek_addr,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_busy,
  output logic              dump_done
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_SEND = SEND;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]        state;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] data_q;

  // Index whose bypassed value gets captured on the coming edge.
  assign peek_addr = (state == S_SEND) ? (idx + ADDR_W'(1)) : '0;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      idx    <= '0;
      data_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (dump_start) begin
            state  <= S_SEND;
            idx    <= '0;
            data_q <= peek_data;
          end
        end
        S_SEND: begin
          if (dump_ready) begin
            if (idx == LAST_IDX) begin
              state <= S_DONE;
            end else begin
              idx    <= peek_addr;
              data_q <= peek_data;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign dump_valid = (state == S_SEND);
  assign dump_busy  = (state == S_SEND);
  assign dump_done  = (state == S_DONE);
  assign dump_addr  = idx;
  assign dump_data  = data_q;

endmodule

// File: rtl/register_file.sv
// 16x16 register file: one synchronous write port, two zero-latency bypassed read ports, dump stream.
// Reads never stall; dump beats wait on dump_ready without blocking reads or writes.
module register_file
  import misc_v_pkg::*;
#(
  parameter bit ZERO_REG = 1'b1
) (
  input  logic            CLK,
  input  logic            reset,
  register_file_if.slave  bus
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_hit;
  logic [ADDR_W-1:0] peek_addr;
  logic [DATA_W-1:0] peek_data;

  assign wr_hit = bus.wr_en && !(ZERO_REG && (bus.wr_addr == '0));

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_hit) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign bus.rd_data_a = read_mux(ZERO_REG, bus.rd_addr_a, wr_hit, bus.wr_addr, bus.wr_data,
                                  regs[bus.rd_addr_a]);
  assign bus.rd_data_b = read_mux(ZERO_REG, bus.rd_addr_b, wr_hit, bus.wr_addr, bus.wr_data,
                                  regs[bus.rd_addr_b]);
  // Third port feeds the dump so a write landing on the capture edge is included.
  assign peek_data     = read_mux(ZERO_REG, peek_addr, wr_hit, bus.wr_addr, bus.wr_data,
                                  regs[peek_addr]);

  reg_dump_fsm u_dump (
    .CLK        (CLK),
    .reset      (reset),
    .dump_start (bus.dump_start),
    .dump_ready (bus.dump_ready),
    .peek_data  (peek_data),
    .peek_addr  (peek_addr),
    .dump_valid (bus.dump_valid),
    .dump_addr  (bus.dump_addr),
    .dump_data  (bus.dump_data),
    .dump_busy  (bus.dump_busy),
    .dump_done  (bus.dump_done)
  );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: vector table, randomized reads against an array model, dump sequences.
module tb_register_file;
  import misc_v_pkg::*;

  logic CLK;
  logic reset;

  register_file_if bus();

  register_file #(.ZERO_REG(1'b1)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] mdl [NUM_REGS];

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] rb;
    logic [DATA_W-1:0] ea;
    logic [DATA_W-1:0] eb;
  } vec_t;

  vec_t vecs [9];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mdl_read(input logic [ADDR_W-1:0] a);
    if (a == '0) return '0;
    if (bus.wr_en && (bus.wr_addr == a)) return bus.wr_data;
    return mdl[a];
  endfunction

  task automatic clear_mdl();
    for (int i = 0; i < NUM_REGS; i++) mdl[i] = '0;
  endtask

  // Advance one edge; the model absorbs whatever write was presented to that edge.
  task automatic step();
    @(posedge CLK);
    if (!reset && bus.wr_en && (bus.wr_addr != '0)) mdl[bus.wr_addr] = bus.wr_data;
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_en      = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.rd_addr_a  = '0;
    bus.rd_addr_b  = '0;
    bus.dump_start = 1'b0;
    bus.dump_ready = 1'b0;
  endtask

  initial begin
    int beats;
    int done_cnt;
    int post;
    int c;
    int k;
    int n;
    int exp_idx;

    vecs[0] = '{1'b1, 4'd3,  16'h8888, 4'd3,  4'd0,  16'h8888, 16'h0000};
    vecs[1] = '{1'b0, 4'd3,  16'h1111, 4'd3,  4'd3,  16'h8888, 16'h8888};
    vecs[2] = '{1'b1, 4'd0,  16'hFFFF, 4'd0,  4'd0,  16'h0000, 16'h0000};
    vecs[3] = '{1'b0, 4'd0,  16'h0000, 4'd0,  4'd3,  16'h0000, 16'h8888};
    vecs[4] = '{1'b1, 4'd5,  16'h1234, 4'd3,  4'd5,  16'h8888, 16'h1234};
    vecs[5] = '{1'b1, 4'd5,  16'hABCD, 4'd5,  4'd5,  16'hABCD, 16'hABCD};
    vecs[6] = '{1'b0, 4'd5,  16'h0000, 4'd5,  4'd4,  16'hABCD, 16'h0000};
    vecs[7] = '{1'b1, 4'd15, 16'h7FFF, 4'd14, 4'd15, 16'h0000, 16'h7FFF};
    vecs[8] = '{1'b0, 4'd15, 16'h0000, 4'd15, 4'd3,  16'h7FFF, 16'h8888};

    reset = 1'b1;
    idle_inputs();
    clear_mdl();
    #3;
    check("rst_valid", 16'(bus.dump_valid), 16'h0);
    check("rst_busy",  16'(bus.dump_busy),  16'h0);
    check("rst_done",  16'(bus.dump_done),  16'h0);
    check("rst_addr",  16'(bus.dump_addr),  16'h0);
    check("rst_data",  bus.dump_data,       16'h0);
    step();
    step();
    reset = 1'b0;

    // Random writes, then reset for two cycles must wipe everything.
    for (int i = 0; i < 20; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 4'($urandom);
      bus.wr_data = 16'($urandom);
      step();
    end
    bus.wr_en = 1'b0;
    reset = 1'b1;
    clear_mdl();
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      bus.rd_addr_a = 4'(i);
      bus.rd_addr_b = 4'(NUM_REGS - 1 - i);
      @(negedge CLK);
      check($sformatf("clr_a%0d", i), bus.rd_data_a, 16'h0);
      check($sformatf("clr_b%0d", i), bus.rd_data_b, 16'h0);
      step();
    end
    check("clr_valid", 16'(bus.dump_valid), 16'h0);

    for (int i = 0; i < 9; i++) begin
      bus.wr_en     = vecs[i].we;
      bus.wr_addr   = vecs[i].wa;
      bus.wr_data   = vecs[i].wd;
      bus.rd_addr_a = vecs[i].ra;
      bus.rd_addr_b = vecs[i].rb;
      @(negedge CLK);
      check($sformatf("vec%0d_a", i), bus.rd_data_a, vecs[i].ea);
      check($sformatf("vec%0d_b", i), bus.rd_data_b, vecs[i].eb);
      step();
    end

    for (int i = 0; i < 300; i++) begin
      bus.wr_en     = 1'($urandom_range(0, 1));
      bus.wr_addr   = 4'($urandom);
      bus.wr_data   = 16'($urandom);
      bus.rd_addr_a = ($urandom_range(0, 3) == 0) ? bus.wr_addr : 4'($urandom);
      bus.rd_addr_b = ($urandom_range(0, 3) == 0) ? bus.wr_addr : 4'($urandom);
      @(negedge CLK);
      check("rand_a", bus.rd_data_a, mdl_read(bus.rd_addr_a));
      check("rand_b", bus.rd_data_b, mdl_read(bus.rd_addr_b));
      step();
    end
    idle_inputs();

    // Dump with ready 1,0,0,1,0,0...; stalled beat's register is overwritten to prove the beat holds.
    for (int i = 0; i < NUM_REGS; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 4'(i);
      bus.wr_data = 16'h0100 + 16'(i);
      step();
    end
    bus.wr_en = 1'b0;
    bus.dump_start = 1'b1;
    step();
    bus.dump_start = 1'b0;
    beats = 0; done_cnt = 0; post = 0; c = 0; exp_idx = 0;
    while (c < 200 && post < 4) begin
      bus.dump_ready = (c % 3 == 0);
      bus.wr_en      = !bus.dump_ready && (beats < NUM_REGS);
      bus.wr_addr    = 4'(exp_idx);
      bus.wr_data    = 16'hDEAD;
      @(negedge CLK);
      check("d5_valid", 16'(bus.dump_valid), 16'(beats < NUM_REGS));
      check("d5_busy",  16'(bus.dump_busy),  16'(beats < NUM_REGS));
      if (bus.dump_valid) begin
        check("d5_addr", 16'(bus.dump_addr), 16'(exp_idx));
        check("d5_data", bus.dump_data, (exp_idx == 0) ? 16'h0 : 16'h0100 + 16'(exp_idx));
        if (bus.dump_ready) begin
          beats++;
          exp_idx++;
        end
      end
      if (bus.dump_done) done_cnt++;
      if (done_cnt > 0) post++;
      bus.dump_start = bus.dump_done || (c == 5);
      step();
      bus.dump_start = 1'b0;
      bus.wr_en = 1'b0;
      c++;
    end
    check("d5_beats", 16'(beats), 16'(NUM_REGS));
    check("d5_done_cnt", 16'(done_cnt), 16'h1);

    // Reset in the middle of a dump, then a fresh dump at full rate.
    bus.dump_ready = 1'b1;
    bus.dump_start = 1'b1;
    step();
    bus.dump_start = 1'b0;
    k = 0; n = 0;
    while (k < 7 && n < 40) begin
      @(negedge CLK);
      check("d6_valid", 16'(bus.dump_valid), 16'h1);
      check("d6_addr",  16'(bus.dump_addr), 16'(k));
      check("d6_data",  bus.dump_data, mdl[k]);
      if (bus.dump_valid) k++;
      step();
      n++;
    end
    @(negedge CLK);
    check("d6_beat7", 16'(bus.dump_addr), 16'h7);
    reset = 1'b1;
    clear_mdl();
    #1;
    check("d6_rst_valid", 16'(bus.dump_valid), 16'h0);
    check("d6_rst_busy",  16'(bus.dump_busy),  16'h0);
    check("d6_rst_addr",  16'(bus.dump_addr),  16'h0);
    check("d6_rst_data",  bus.dump_data,       16'h0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      check("d6_no_restart", 16'(bus.dump_valid), 16'h0);
      step();
    end
    bus.dump_start = 1'b1;
    step();
    bus.dump_start = 1'b0;
    k = 0; n = 0;
    while (k < NUM_REGS && n < 40) begin
      @(negedge CLK);
      check("d6r_valid", 16'(bus.dump_valid), 16'h1);
      check("d6r_addr",  16'(bus.dump_addr), 16'(k));
      check("d6r_data",  bus.dump_data, 16'h0);
      if (bus.dump_valid) k++;
      step();
      n++;
    end
    check("d6r_len", 16'(n), 16'(NUM_REGS));
    @(negedge CLK);
    check("d6r_done", 16'(bus.dump_done), 16'h1);
    check("d6r_valid_end", 16'(bus.dump_valid), 16'h0);
    step();
    @(negedge CLK);
    check("d6r_done_pulse", 16'(bus.dump_done), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
